ex_mem_pipe: RTL
================

Name: ex_mem_pipe

Overview:
- Execute-to-memory pipeline stage. Sits directly downstream of the execute-stage ALU and captures its 32-bit result and error flag with the instruction's control fields.
- Provides a valid/ready handshake on both sides with a 2-entry skid buffer, so a memory-side stall never creates a combinational ready path back into execute.
- Handles pipeline flush, squashes side effects of ALU-error instructions, and holds a sticky error record for the exception logic.

Parameters:
- DW, REGFILE_WIDTH (32), datapath width of ALU result, PC and store data.
- RW, 5, destination register index width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  discard all held and incoming packets
- in_valid  in  1  execute stage presents a packet
- in_ready  out  1  stage can accept; registered, equals ~skid_full
- in_alu_out  in  DW  ALU Out
- in_alu_err  in  1  ALU alu_err
- in_pc  in  DW  instruction PC
- in_rd  in  RW  destination register
- in_wr_en  in  1  register write enable
- in_mem_rd  in  1  load
- in_mem_wr  in  1  store
- in_st_data  in  DW  store data
- out_valid  out  1  packet available to memory stage
- out_ready  in  1  memory stage accepts
- out_alu_out, out_pc, out_st_data  out  DW  registered copies
- out_rd  out  RW  registered copy
- out_wr_en, out_mem_rd, out_mem_wr  out  1  registered, squashed on error
- out_err  out  1  packet carried alu_err
- err_valid  out  1  sticky error flag
- err_pc  out  DW  PC of first unacknowledged error
- err_clr  in  1  clear sticky error

Behaviour:
- Reset (async): all outputs 0, both entries empty, in_ready=1, err_valid=0, err_pc=0.
- Storage: main entry drives the out_* ports; skid entry holds overflow.
- Accept: in_valid & in_ready.
- Output fire: out_valid & out_ready.
- Latency: a packet accepted at edge N appears on out_* after that edge when main was empty or firing; 1 packet/cycle sustained while out_ready=1.
- Accept with main occupied and not firing: packet goes to skid; in_ready drops next cycle.
- Main fires while skid is full: skid moves to main on that edge and in_ready rises next cycle.
- Main fires with skid full and an accept in the same cycle: cannot occur, since in_ready=0.
- Ordering: strict FIFO; no packet is lost or duplicated.
- out_* hold stable while out_valid & ~out_ready.
- Squash: when in_alu_err=1 the stored wr_en, mem_rd and mem_wr are forced 0 and out_err=1; the packet still flows so the memory stage can retire it.
- Sticky error:
  - On accept of an error packet with err_valid=0: set err_valid and capture err_pc.
  - If err_valid is already 1, keep the first PC.
  - err_clr clears err_valid.
  - err_clr together with accept of a new error packet: the new error is captured (set wins).
- Flush:
  - At the next edge both entries become empty and out_valid=0.
  - Any same-cycle input is discarded.
  - in_ready=1 the following cycle.
  - The sticky error register is unaffected.
- Reset mid-operation empties everything immediately.

Optional Feature:
- Macro EX_MEM_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0]. It increments each cycle with out_valid & ~out_ready, saturates at 32'hFFFF_FFFF and resets to 0. Flush does not clear it.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package wi23_defs gains:
  - ex_mem_pkt_t, a packed struct of alu_out, pc, st_data, rd, wr_en, mem_rd, mem_wr, err;
  - EX_MEM_RW = 5.
- Both entries and all out_* ports use ex_mem_pkt_t.
- One natural sub-module: skid_buf, a generic 2-entry valid/ready skid buffer parameterised on payload width. ex_mem_pipe wraps it and adds squash, flush and the error register.

Test Plan:
- Streaming: out_ready=1; send 4 packets with alu_out 0x1,0x2,0x3,0x4 on consecutive cycles -> out_valid for 4 consecutive cycles, 1-cycle latency, same order, in_ready stays 1.
- Backpressure: out_ready=0; send 0xA then 0xB -> in_ready=0 after the second accept. Raise out_ready -> 0xA then 0xB delivered; in_ready returns to 1 one cycle after 0xA fires.
- Error squash: packet with in_alu_err=1, pc=0x100, wr_en=1, mem_wr=1 -> out_err=1, out_wr_en=0, out_mem_wr=0, err_valid=1, err_pc=0x100.
  - A second error with pc=0x200 leaves err_pc=0x100.
  - err_clr with a third error at pc=0x300 in the same cycle -> err_valid=1, err_pc=0x300.
- Flush with both entries full and in_valid=1 -> out_valid=0 next cycle, no packet ever emitted, in_ready=1, err_valid unchanged.
- Async reset asserted mid-cycle while out_valid=1 -> outputs 0 before the next clock edge; after release, a packet with alu_out 0x55 passes normally.
- With EX_MEM_STALL_CNT_EN: hold out_ready=0 for 7 cycles with a packet held -> stall_cnt=7.

Source files
------------

// File: rtl/wi23_defs.sv
// rtl/wi23_defs.sv - shared widths and the execute-to-memory packet type
package wi23_defs;

    localparam int REGFILE_WIDTH = 32;
    localparam int EX_MEM_RW     = 5;

    typedef struct packed {
        logic [REGFILE_WIDTH-1:0] alu_out;
        logic [REGFILE_WIDTH-1:0] pc;
        logic [REGFILE_WIDTH-1:0] st_data;
        logic [EX_MEM_RW-1:0]     rd;
        logic                     wr_en;
        logic                     mem_rd;
        logic                     mem_wr;
        logic                     err;
    } ex_mem_pkt_t;

endpackage

// File: rtl/ex_mem_pipe_skid_buf.sv
// rtl/ex_mem_pipe_skid_buf.sv - generic 2-entry valid/ready skid buffer
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         main_valid;
    logic         skid_valid;
    logic         accept;
    logic         fire;

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign accept    = in_valid & in_ready;
    assign fire      = main_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data  <= '0;
            skid_data  <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || fire) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX/MEM stage: skid-buffered handoff, error squash, sticky error record
// Optional stall counter output enabled by EX_MEM_STALL_CNT_EN.
module ex_mem_pipe
    import wi23_defs::*;
#(
    parameter int DW = REGFILE_WIDTH,
    parameter int RW = EX_MEM_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_alu_out,
    input  logic          in_alu_err,
    input  logic [DW-1:0] in_pc,
    input  logic [RW-1:0] in_rd,
    input  logic          in_wr_en,
    input  logic          in_mem_rd,
    input  logic          in_mem_wr,
    input  logic [DW-1:0] in_st_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_alu_out,
    output logic [DW-1:0] out_pc,
    output logic [DW-1:0] out_st_data,
    output logic [RW-1:0] out_rd,
    output logic          out_wr_en,
    output logic          out_mem_rd,
    output logic          out_mem_wr,
    output logic          out_err,
    output logic          err_valid,
    output logic [DW-1:0] err_pc,
`ifdef EX_MEM_STALL_CNT_EN
    output logic [31:0]   stall_cnt,
`endif
    input  logic          err_clr
);

    ex_mem_pkt_t pkt_in;
    ex_mem_pkt_t pkt_out;
    logic        err_set;

    // Erroring instructions still flow so memory can retire them, but lose side effects
    always_comb begin
        pkt_in         = '0;
        pkt_in.alu_out = in_alu_out;
        pkt_in.pc      = in_pc;
        pkt_in.st_data = in_st_data;
        pkt_in.rd      = in_rd;
        pkt_in.wr_en   = in_wr_en  & ~in_alu_err;
        pkt_in.mem_rd  = in_mem_rd & ~in_alu_err;
        pkt_in.mem_wr  = in_mem_wr & ~in_alu_err;
        pkt_in.err     = in_alu_err;
    end

    skid_buf #(
        .W($bits(ex_mem_pkt_t))
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (pkt_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (pkt_out)
    );

    assign out_alu_out = pkt_out.alu_out;
    assign out_pc      = pkt_out.pc;
    assign out_st_data = pkt_out.st_data;
    assign out_rd      = pkt_out.rd;
    assign out_wr_en   = pkt_out.wr_en;
    assign out_mem_rd  = pkt_out.mem_rd;
    assign out_mem_wr  = pkt_out.mem_wr;
    assign out_err     = pkt_out.err;

    // A packet discarded by flush never counts as accepted, so it cannot record an error
    assign err_set = in_valid & in_ready & ~flush & in_alu_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_pc    <= '0;
        end else if (err_set && (!err_valid || err_clr)) begin
            err_valid <= 1'b1;
            err_pc    <= in_pc;
        end else if (err_clr) begin
            err_valid <= 1'b0;
        end
    end

`ifdef EX_MEM_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
